// File: rtl/gimbal_pkg.sv
// Shared types, widths and the per-frame step-count rule for the gimbal step scheduler.
package gimbal_pkg;

    localparam int ERR_W = 11;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_MOVE,
        ST_SETTLE,
        ST_LOST,
        ST_HOME
    } state_t;

    // Deadband first, then gain, then clamp; a just-outside-deadband error still gets one step.
    function automatic logic [CNT_W-1:0] calc_steps(input logic signed [ERR_W-1:0] e,
                                                     input int deadband,
                                                     input int gain_shift,
                                                     input int max_steps);
        logic [ERR_W-1:0] mag;
        logic [ERR_W-1:0] sh;
        mag = e[ERR_W-1] ? $unsigned(-e) : $unsigned(e);
        sh  = mag >> gain_shift;
        if (int'(mag) <= deadband)
            return '0;
        else if (sh == '0)
            return CNT_W'(1);
        else if (int'(sh) > max_steps)
            return CNT_W'(max_steps);
        else
            return CNT_W'(sh);
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// One stepper axis: emits `count` STEP pulses, one per STEP_PERIOD slot, first pulse
// one cycle after start. abort lets a high pulse finish its width, then stops.
module step_pulse_gen
    import gimbal_pkg::*;
#(
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_WIDTH = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             dir,
    input  logic             abort,
    output logic             step,
    output logic             step_dir,
    output logic             done
);

    localparam int SLOT_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(STEP_PERIOD - 1);
    localparam logic [SLOT_W-1:0] PW_LAST   = SLOT_W'(PULSE_WIDTH - 1);

    logic [SLOT_W-1:0] slot;
    logic [CNT_W-1:0]  remain;
    logic              armed;
    logic              run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot     <= '0;
            remain   <= '0;
            armed    <= 1'b0;
            run      <= 1'b0;
            step_dir <= 1'b0;
        end else if (start) begin
            armed    <= 1'b1;
            run      <= 1'b0;
            remain   <= count;
            slot     <= '0;
            step_dir <= dir;
        end else if (armed) begin
            // one-cycle gap so DIR settles before the first rising edge
            armed <= 1'b0;
            run   <= (remain != '0) && !abort;
            slot  <= '0;
        end else if (run) begin
            if (abort && slot >= PW_LAST) begin
                run <= 1'b0;
            end else if (slot == SLOT_LAST) begin
                slot   <= '0;
                remain <= remain - 1'b1;
                run    <= (remain != CNT_W'(1));
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

    assign step = run && (slot < SLOT_W'(PULSE_WIDTH));
    assign done = !armed && !run;

endmodule

// File: rtl/gimbal_step_scheduler.sv
// Per-frame pan/tilt step scheduler with target-loss tracking.
// Optional GIMBAL_HOME_RETURN_EN: track position and step back to origin on loss.
module gimbal_step_scheduler
    import gimbal_pkg::*;
#(
    parameter int CENTER_X    = 320,
    parameter int CENTER_Y    = 240,
    parameter int DEADBAND    = 8,
    parameter int GAIN_SHIFT  = 2,
    parameter int MAX_STEPS   = 32,
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_WIDTH = 250,
    parameter int SETTLE_CYC  = 100000,
    parameter int LOST_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       is_locked,
    input  logic       target_valid,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    output logic       pan_step,
    output logic       pan_dir,
    output logic       tilt_step,
    output logic       tilt_dir,
    output logic       motor_en,
    output logic       busy,
    output logic       lost
);

    localparam int LOST_W = $clog2(LOST_FRAMES + 1);
    localparam int SET_W  = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
`ifdef GIMBAL_HOME_RETURN_EN
    localparam state_t LOST_ENTRY = ST_HOME;
`else
    localparam state_t LOST_ENTRY = ST_LOST;
`endif

    state_t                  state, state_nxt;
    logic [LOST_W-1:0]       lost_cnt;
    logic [SET_W-1:0]        settle_cnt;
    logic [9:0]              tgt_x, tgt_y;
    logic                    halt_q, halt_d;
    logic                    motor_en_d;
    logic                    pan_start, tilt_start, gen_abort;
    logic [CNT_W-1:0]        pan_cnt, tilt_cnt;
    logic                    pan_dir_d, tilt_dir_d;
    logic                    pan_done, tilt_done;
    logic signed [ERR_W-1:0] ex, ey;
    logic [CNT_W-1:0]        ex_steps, ey_steps;
    logic                    good_frame, lost_hit, both_done, stop_req;

    assign ex       = $signed({1'b0, tgt_x}) - ERR_W'(CENTER_X);
    assign ey       = $signed({1'b0, tgt_y}) - ERR_W'(CENTER_Y);
    assign ex_steps = calc_steps(ex, DEADBAND, GAIN_SHIFT, MAX_STEPS);
    assign ey_steps = calc_steps(ey, DEADBAND, GAIN_SHIFT, MAX_STEPS);

    assign good_frame = frame_tick && is_locked && target_valid;
    assign lost_hit   = (lost_cnt == LOST_W'(LOST_FRAMES));
    assign both_done  = pan_done && tilt_done;
    assign stop_req   = lost_hit || !is_locked;

`ifdef GIMBAL_HOME_RETURN_EN
    logic signed [15:0] pos_x, pos_y;
    logic               pan_step_q, tilt_step_q;

    function automatic logic [CNT_W-1:0] home_steps(input logic signed [15:0] p);
        logic [15:0] m;
        m = p[15] ? $unsigned(-p) : $unsigned(p);
        return (m > 16'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : CNT_W'(m);
    endfunction

    // every issued pulse moves the axis one step in its latched direction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_x       <= '0;
            pos_y       <= '0;
            pan_step_q  <= 1'b0;
            tilt_step_q <= 1'b0;
        end else begin
            pan_step_q  <= pan_step;
            tilt_step_q <= tilt_step;
            if (pan_step && !pan_step_q)
                pos_x <= pos_x + (pan_dir ? 16'sd1 : -16'sd1);
            if (tilt_step && !tilt_step_q)
                pos_y <= pos_y + (tilt_dir ? 16'sd1 : -16'sd1);
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        halt_d     = halt_q;
        gen_abort  = halt_q;
        pan_start  = 1'b0;
        tilt_start = 1'b0;
        pan_cnt    = ex_steps;
        tilt_cnt   = ey_steps;
        pan_dir_d  = !ex[ERR_W-1] && (ex != '0);
        tilt_dir_d = !ey[ERR_W-1] && (ey != '0);
        case (state)
            ST_IDLE: begin
                if (lost_hit)        state_nxt = LOST_ENTRY;
                else if (good_frame) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (lost_hit)                                 state_nxt = LOST_ENTRY;
                else if (!is_locked)                          state_nxt = ST_IDLE;
                else if (ex_steps == '0 && ey_steps == '0)    state_nxt = ST_IDLE;
                else begin
                    pan_start  = 1'b1;
                    tilt_start = 1'b1;
                    state_nxt  = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // halt is sticky so a brief lock glitch still ends the burst
                gen_abort = halt_q || stop_req;
                if (stop_req) halt_d = 1'b1;
                if (both_done) begin
                    halt_d = 1'b0;
                    if (lost_hit)                    state_nxt = LOST_ENTRY;
                    else if (halt_q || !is_locked)   state_nxt = ST_IDLE;
                    else                             state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (lost_hit)                                  state_nxt = LOST_ENTRY;
                else if (!is_locked)                           state_nxt = ST_IDLE;
                else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = ST_IDLE;
            end
            ST_LOST: begin
                if (good_frame) state_nxt = ST_IDLE;
            end
`ifdef GIMBAL_HOME_RETURN_EN
            ST_HOME: begin
                gen_abort = halt_q || good_frame;
                if (good_frame) halt_d = 1'b1;
                if (both_done) begin
                    if (halt_q || good_frame) begin
                        halt_d    = 1'b0;
                        state_nxt = ST_IDLE;
                    end else if (pos_x == '0 && pos_y == '0) begin
                        state_nxt = ST_LOST;
                    end else begin
                        pan_start  = 1'b1;
                        tilt_start = 1'b1;
                        pan_cnt    = home_steps(pos_x);
                        tilt_cnt   = home_steps(pos_y);
                        pan_dir_d  = pos_x[15];
                        tilt_dir_d = pos_y[15];
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_IDLE: motor_en_d = is_locked;
            ST_LOST: motor_en_d = 1'b0;
            default: motor_en_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            lost_cnt   <= '0;
            settle_cnt <= '0;
            tgt_x      <= '0;
            tgt_y      <= '0;
            halt_q     <= 1'b0;
            motor_en   <= 1'b0;
        end else begin
            state      <= state_nxt;
            halt_q     <= halt_d;
            motor_en   <= motor_en_d;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (state == ST_IDLE && good_frame) begin
                tgt_x <= target_x;
                tgt_y <= target_y;
            end
            if (frame_tick) begin
                if (!is_locked || target_valid) lost_cnt <= '0;
                else if (!lost_hit)             lost_cnt <= lost_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == ST_SAMPLE) || (state == ST_MOVE) || (state == ST_SETTLE);
    assign lost = (state == ST_LOST);

    step_pulse_gen #(.STEP_PERIOD(STEP_PERIOD), .PULSE_WIDTH(PULSE_WIDTH)) u_pan (
        .clk      (clk),
        .reset    (reset),
        .start    (pan_start),
        .count    (pan_cnt),
        .dir      (pan_dir_d),
        .abort    (gen_abort),
        .step     (pan_step),
        .step_dir (pan_dir),
        .done     (pan_done)
    );

    step_pulse_gen #(.STEP_PERIOD(STEP_PERIOD), .PULSE_WIDTH(PULSE_WIDTH)) u_tilt (
        .clk      (clk),
        .reset    (reset),
        .start    (tilt_start),
        .count    (tilt_cnt),
        .dir      (tilt_dir_d),
        .abort    (gen_abort),
        .step     (tilt_step),
        .step_dir (tilt_dir),
        .done     (tilt_done)
    );

endmodule

// File: tb/tb_gimbal_step_scheduler.sv
// Randomized + directed bench for gimbal_step_scheduler against a frame-level reference model.
module tb_gimbal_step_scheduler;

    localparam int SP = 20;
    localparam int PW = 5;
    localparam int SC = 10;
    localparam int LF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       is_locked = 1'b1;
    logic       target_valid = 1'b1;
    logic [9:0] target_x = 10'd320;
    logic [9:0] target_y = 10'd240;
    logic       pan_step, pan_dir, tilt_step, tilt_dir, motor_en, busy, lost;

    int n_chk = 0;
    int n_err = 0;

    gimbal_step_scheduler #(
        .STEP_PERIOD (SP),
        .PULSE_WIDTH (PW),
        .SETTLE_CYC  (SC),
        .LOST_FRAMES (LF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .is_locked    (is_locked),
        .target_valid (target_valid),
        .target_x     (target_x),
        .target_y     (target_y),
        .pan_step     (pan_step),
        .pan_dir      (pan_dir),
        .tilt_step    (tilt_step),
        .tilt_dir     (tilt_dir),
        .motor_en     (motor_en),
        .busy         (busy),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic v);
        target_valid = v;
        frame_tick   = 1'b1;
        tick();
        frame_tick   = 1'b0;
    endtask

    // Reference: steps from pixel error per the deadband/gain/clamp rule.
    function automatic int model_steps(input int c, input int ctr);
        int m;
        m = (c >= ctr) ? c - ctr : ctr - c;
        if (m <= 8) return 0;
        m = m / 4;
        if (m < 1)  return 1;
        if (m > 32) return 32;
        return m;
    endfunction

    task automatic wait_rise(output bit ok);
        logic prev;
        prev = pan_step;
        ok   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pan_step && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = pan_step;
        end
    endtask

    task automatic burst(input string tag, input int x, input int y);
        int ep, et, np, nt, pfirst, tfirst, plast, tlast, pw, tw, blen, n;
        int bad_w, bad_p, bad_dir, bad_al, bad_en;
        logic pp, tp, pd_prev, td_prev;
        ep = model_steps(x, 320);
        et = model_steps(y, 240);
        np = 0; nt = 0; pfirst = -1; tfirst = -1; plast = 0; tlast = 0; pw = 0; tw = 0;
        blen = -1; bad_w = 0; bad_p = 0; bad_dir = 0; bad_al = 0; bad_en = 0;
        pp = 1'b0; tp = 1'b0; pd_prev = pan_dir; td_prev = tilt_dir;
        target_x = 10'(x);
        target_y = 10'(y);
        is_locked = 1'b1;
        frame(1'b1);
        for (int k = 0; k < 1500 && blen < 0; k++) begin
            if (k > 0) tick();
            if (!busy) blen = k;
            if (busy && !motor_en) bad_en++;
            if (pan_step && !pp) begin
                np++;
                if (np == 1) pfirst = k;
                else if (k - plast != SP) bad_p++;
                plast = k;
                if (pan_dir != (x > 320) || pd_prev != (x > 320)) bad_dir++;
            end
            if (tilt_step && !tp) begin
                nt++;
                if (nt == 1) tfirst = k;
                else if (k - tlast != SP) bad_p++;
                tlast = k;
                if (tilt_dir != (y > 240) || td_prev != (y > 240)) bad_dir++;
            end
            if (pan_step) pw++;
            else begin
                if (pp && pw != PW) bad_w++;
                pw = 0;
            end
            if (tilt_step) tw++;
            else begin
                if (tp && tw != PW) bad_w++;
                tw = 0;
            end
            if (ep == et && pan_step != tilt_step) bad_al++;
            pp = pan_step; tp = tilt_step; pd_prev = pan_dir; td_prev = tilt_dir;
        end
        chk({tag, "_done"},   int'(blen >= 0), 1);
        chk({tag, "_pan_n"},  np, ep);
        chk({tag, "_tilt_n"}, nt, et);
        if (ep > 0) chk({tag, "_pan_first"}, pfirst, 2);
        if (et > 0) chk({tag, "_tilt_first"}, tfirst, 2);
        chk({tag, "_width"},  bad_w, 0);
        chk({tag, "_period"}, bad_p, 0);
        chk({tag, "_dir"},    bad_dir, 0);
        chk({tag, "_align"},  bad_al, 0);
        chk({tag, "_en"},     bad_en, 0);
        n = (ep > et) ? ep : et;
        if (n == 0) chk({tag, "_busy_len"}, blen, 1);
        else        chk({tag, "_busy_len_ok"},
                        int'(blen >= n * SP + SC + 2 && blen <= n * SP + SC + 4), 1);
        tick();
    endtask

    initial begin
        bit   ok;
        int   hi, rises, act;
        logic inp, prev;

        repeat (3) tick();
        chk("reset_outs", int'({pan_step, pan_dir, tilt_step, tilt_dir, motor_en, busy, lost}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_en", int'({motor_en, busy, lost}), 3'b100);

        burst("centre",  320, 240);
        burst("right",   420, 240);
        burst("clamp",   0,   479);
        burst("db_8",    328, 240);
        burst("db_9",    329, 240);
        burst("db_2",    322, 240);
        for (int i = 0; i < 6; i++)
            burst("rand", int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

        // loss during MOVE: third invalid frame lands just after a rising edge
        target_x = 10'd420;
        target_y = 10'd240;
        frame(1'b1);
        repeat (30) tick();
        frame(1'b0);
        tick();
        frame(1'b0);
        wait_rise(ok);
        chk("loss_rise_seen", int'(ok), 1);
        hi = 1; inp = 1'b1; prev = 1'b1; rises = 0;
        frame(1'b0);
        for (int j = 0; j < 200; j++) begin
            if (j > 0) tick();
            if (inp) begin
                if (pan_step) hi++;
                else inp = 1'b0;
            end else if (pan_step && !prev) begin
                rises++;
            end
            prev = pan_step;
        end
        chk("loss_pulse_w", hi, PW);
        chk("loss_no_new", rises, 0);
        chk("loss_state", int'({lost, motor_en, busy}), 3'b100);
        frame(1'b1);
        chk("loss_exit_lost", int'(lost), 0);
        tick();
        chk("loss_exit_idle", int'({motor_en, busy}), 2'b10);

        // asynchronous reset while a pan pulse is high
        target_x = 10'd420;
        target_y = 10'd240;
        frame(1'b1);
        wait_rise(ok);
        chk("rst_rise_seen", int'(ok), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_mid", int'({pan_step, pan_dir, tilt_step, tilt_dir, motor_en, busy, lost}), 0);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        act = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (pan_step || tilt_step || busy || lost) act++;
        end
        chk("rst_quiet", act, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
